// File: rtl/memlane_pkg.sv
// Shared definitions for the data-memory byte-lane path: load/store
// opcodes, store-writer FSM encoding and lane geometry.
package memlane_pkg;

  localparam int NUM_LANES = 4;
  localparam int OP_W      = 6;

  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

  // IDLE: no write beat on the outputs; BEAT0: first (or only) beat driven;
  // BEAT1: second beat of a word-crossing store driven.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } st_state_e;

  // Unshifted byte-enable pattern for a store opcode (0 = not a store).
  function automatic logic [NUM_LANES-1:0] st_base_mask(input logic [OP_W-1:0] op);
    case (op)
      OP_SB:   st_base_mask = 4'b0001;
      OP_SH:   st_base_mask = 4'b0011;
      OP_SW:   st_base_mask = 4'b1111;
      default: st_base_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/memin_lane_align.sv
// Combinational store aligner: rotates the store value onto the four byte
// lanes for a given lane offset and produces the 7-bit shifted enable mask
// (bits [6:4] are the lanes that spill into the next word).
module memin_lane_align
  import memlane_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [OP_W-1:0]                       opcode,
  input  logic [1:0]                            off,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]       st_data,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  lane_data,
  output logic [6:0]                            we_mask,
  output logic                                  is_store
);

  logic [NUM_LANES-1:0] base;

  // Opcode decode and shift of the enable pattern by the lane offset
  always_comb begin
    base     = st_base_mask(opcode);
    is_store = |base;
    we_mask  = {3'b000, base} << off;
  end

  // Lane i carries source byte (i - off) mod 4
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [1:0] src;
    assign src           = 2'(gi) - off;
    assign lane_data[gi] = st_data[int'(src)*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: rtl/memin_w0.sv
// Store-side byte-lane writer for four byte-wide data memories.
// Accepts sb/sh/sw over StValid/StReady, drives rotated lane data, per-lane
// write enables and the word address, all from registers.
// Optional feature macro: MEMIN_SPLIT_EN -- word-crossing sh/sw are written
// as two beats on consecutive words; without it such stores are dropped and
// AlignErr pulses.
module memin_w0
  import memlane_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  StValid,
  output logic                  StReady,
  input  logic [OP_W-1:0]       Opcode,
  input  logic [31:0]           Addr,
  input  logic [31:0]           StData,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] Mem0In,
  output logic [DATA_WIDTH-1:0] Mem1In,
  output logic [DATA_WIDTH-1:0] Mem2In,
  output logic [DATA_WIDTH-1:0] Mem3In,
  output logic [NUM_LANES-1:0]  MemWe,
  output logic                  AlignErr
);

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] al_lanes;
  logic [6:0]                           al_mask;
  logic                                 al_store;
  logic                                 al_split;
  logic                                 accept;
  logic                                 unused_addr_hi;

  st_state_e                            state_q, state_d;
  logic [NUM_LANES-1:0]                 we_q, we_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_q, lane_d;
  logic                                 err_q, err_d;
`ifdef MEMIN_SPLIT_EN
  logic [2:0]                           hi_we_q, hi_we_d;
`endif

  memin_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .opcode    (Opcode),
    .off       (Addr[1:0]),
    .st_data   (StData),
    .lane_data (al_lanes),
    .we_mask   (al_mask),
    .is_store  (al_store)
  );

  assign unused_addr_hi = ^Addr[31:ADDR_WIDTH+2];
  assign al_split       = |al_mask[6:4];

  // Ready drops only while beat 0 of a split is on the outputs, since the
  // next cycle is reserved for beat 1.
`ifdef MEMIN_SPLIT_EN
  assign StReady = !((state_q == ST_BEAT0) && (hi_we_q != 3'b000));
`else
  assign StReady = 1'b1;
`endif
  assign accept  = StValid & StReady;

  // Next-state and next-output computation for the write-beat FSM
  always_comb begin
    state_d = state_q;
    we_d    = '0;
    addr_d  = addr_q;
    lane_d  = lane_q;
    err_d   = 1'b0;
`ifdef MEMIN_SPLIT_EN
    hi_we_d = hi_we_q;
    if ((state_q == ST_BEAT0) && (hi_we_q != 3'b000)) begin
      // second beat: same rotated lanes, next word, spill enables
      we_d    = {1'b0, hi_we_q};
      addr_d  = addr_q + ADDR_WIDTH'(1);
      hi_we_d = 3'b000;
      state_d = ST_BEAT1;
    end else if (accept && al_store) begin
      we_d    = al_mask[3:0];
      addr_d  = Addr[ADDR_WIDTH+1:2];
      lane_d  = al_lanes;
      hi_we_d = al_mask[6:4];
      state_d = ST_BEAT0;
    end else begin
      state_d = ST_IDLE;
    end
`else
    if (accept && al_store && al_split) begin
      // word-crossing store cannot be written: drop and flag it
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (accept && al_store) begin
      we_d    = al_mask[3:0];
      addr_d  = Addr[ADDR_WIDTH+1:2];
      lane_d  = al_lanes;
      state_d = ST_BEAT0;
    end else if (state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
`endif
  end

  // State and output registers; reset drops any pending second beat
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      err_q   <= 1'b0;
`ifdef MEMIN_SPLIT_EN
      hi_we_q <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
`ifdef MEMIN_SPLIT_EN
      hi_we_q <= hi_we_d;
`endif
    end
  end

  assign MemWe    = we_q;
  assign MemAddr  = addr_q;
  assign AlignErr = err_q;
  assign Mem0In   = lane_q[0];
  assign Mem1In   = lane_q[1];
  assign Mem2In   = lane_q[2];
  assign Mem3In   = lane_q[3];

endmodule

// File: tb/tb_memin_w0.sv
// Directed bench for memin_w0: drives stores on the falling edge, samples
// outputs on the following falling edge (cycle N+1 after the accepting edge).
// Expectations follow the build: MEMIN_SPLIT_EN selects split vs drop.
module tb_memin_w0;

  localparam int AW = 10;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          StValid;
  logic          StReady;
  logic [5:0]    Opcode;
  logic [31:0]   Addr;
  logic [31:0]   StData;
  logic [AW-1:0] MemAddr;
  logic [7:0]    Mem0In, Mem1In, Mem2In, Mem3In;
  logic [3:0]    MemWe;
  logic          AlignErr;

  int checks = 0;
  int errors = 0;

  memin_w0 #(.DATA_WIDTH(8), .ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .StValid(StValid), .StReady(StReady),
    .Opcode(Opcode), .Addr(Addr), .StData(StData), .MemAddr(MemAddr),
    .Mem0In(Mem0In), .Mem1In(Mem1In), .Mem2In(Mem2In), .Mem3In(Mem3In),
    .MemWe(MemWe), .AlignErr(AlignErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    StValid = v; Opcode = op; Addr = a; StData = d;
  endtask

  initial begin
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    Rst_n = 1'b0;
    #12;
    chk("rst_we", 32'(MemWe), 32'h0);
    chk("rst_addr", 32'(MemAddr), 32'h0);
    chk("rst_lane0", 32'(Mem0In), 32'h0);
    chk("rst_err", 32'(AlignErr), 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(StReady), 32'h1);
    @(negedge Clk);

    // sb at byte 6: lane 2, word 1
    drive(1'b1, 6'h28, 32'h0000_0006, 32'h0000_00A5);
    cyc();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    chk("sb_we", 32'(MemWe), 32'h4);
    chk("sb_lane2", 32'(Mem2In), 32'hA5);
    chk("sb_addr", 32'(MemAddr), 32'h1);
    chk("sb_err", 32'(AlignErr), 32'h0);
    cyc();
    chk("idle_we", 32'(MemWe), 32'h0);
    chk("idle_hold_lane2", 32'(Mem2In), 32'hA5);

    // sh at byte 2: lanes 3:2, word 0
    drive(1'b1, 6'h29, 32'h0000_0002, 32'h0000_BEEF);
    cyc();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    chk("sh_we", 32'(MemWe), 32'hC);
    chk("sh_lane3", 32'(Mem3In), 32'hBE);
    chk("sh_lane2", 32'(Mem2In), 32'hEF);
    chk("sh_addr", 32'(MemAddr), 32'h0);
    cyc();

    // back-to-back aligned sw then sb, one per cycle
    drive(1'b1, 6'h2B, 32'h0000_0010, 32'hDEAD_BEEF);
    cyc();
    chk("b2b_sw_we", 32'(MemWe), 32'hF);
    chk("b2b_sw_addr", 32'(MemAddr), 32'h4);
    chk("b2b_sw_lanes", {Mem3In, Mem2In, Mem1In, Mem0In}, 32'hDEAD_BEEF);
    chk("b2b_ready", 32'(StReady), 32'h1);
    drive(1'b1, 6'h28, 32'h0000_0015, 32'h0000_0077);
    cyc();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    chk("b2b_sb_we", 32'(MemWe), 32'h2);
    chk("b2b_sb_lane1", 32'(Mem1In), 32'h77);
    chk("b2b_sb_addr", 32'(MemAddr), 32'h5);
    cyc();

    // sw at byte 9 crosses into word 3
    drive(1'b1, 6'h2B, 32'h0000_0009, 32'h1122_3344);
    cyc();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
`ifdef MEMIN_SPLIT_EN
    chk("split_b0_we", 32'(MemWe), 32'hE);
    chk("split_b0_addr", 32'(MemAddr), 32'h2);
    chk("split_b0_lanes", {8'h0, Mem3In, Mem2In, Mem1In}, 32'h0022_3344);
    chk("split_b0_ready", 32'(StReady), 32'h0);
    cyc();
    chk("split_b1_we", 32'(MemWe), 32'h1);
    chk("split_b1_addr", 32'(MemAddr), 32'h3);
    chk("split_b1_lane0", 32'(Mem0In), 32'h11);
    chk("split_b1_ready", 32'(StReady), 32'h1);
    cyc();
    chk("split_done_we", 32'(MemWe), 32'h0);
`else
    chk("drop_we", 32'(MemWe), 32'h0);
    chk("drop_err", 32'(AlignErr), 32'h1);
    chk("drop_ready", 32'(StReady), 32'h1);
    chk("drop_hold_addr", 32'(MemAddr), 32'h5);
    chk("drop_hold_lane1", 32'(Mem1In), 32'h77);
    cyc();
    chk("drop_we2", 32'(MemWe), 32'h0);
    chk("drop_err_pulse", 32'(AlignErr), 32'h0);
`endif

    // sh at the last byte of the last word: beat 1 wraps to word 0
    drive(1'b1, 6'h29, 32'((2**AW - 1) * 4 + 3), 32'h0000_CAFE);
    cyc();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
`ifdef MEMIN_SPLIT_EN
    chk("wrap_b0_we", 32'(MemWe), 32'h8);
    chk("wrap_b0_addr", 32'(MemAddr), 32'(2**AW - 1));
    chk("wrap_b0_lane3", 32'(Mem3In), 32'hFE);
    cyc();
    chk("wrap_b1_we", 32'(MemWe), 32'h1);
    chk("wrap_b1_addr", 32'(MemAddr), 32'h0);
    chk("wrap_b1_lane0", 32'(Mem0In), 32'hCA);
`else
    chk("wrap_drop_we", 32'(MemWe), 32'h0);
    chk("wrap_drop_err", 32'(AlignErr), 32'h1);
`endif
    cyc();

    // sb at offset 3 never crosses
    drive(1'b1, 6'h28, 32'h0000_0007, 32'h0000_005A);
    cyc();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    chk("sb_off3_we", 32'(MemWe), 32'h8);
    chk("sb_off3_lane3", 32'(Mem3In), 32'h5A);
    chk("sb_off3_err", 32'(AlignErr), 32'h0);
    cyc();

    // reset while a store's first beat is on the outputs
`ifdef MEMIN_SPLIT_EN
    drive(1'b1, 6'h2B, 32'h0000_0009, 32'h1122_3344);
    cyc();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    chk("rstmid_b0_we", 32'(MemWe), 32'hE);
`else
    drive(1'b1, 6'h2B, 32'h0000_0020, 32'h1122_3344);
    cyc();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    chk("rstmid_b0_we", 32'(MemWe), 32'hF);
`endif
    Rst_n = 1'b0;
    #1;
    chk("rstmid_we", 32'(MemWe), 32'h0);
    chk("rstmid_addr", 32'(MemAddr), 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc();
    chk("rstmid_no_b1", 32'(MemWe), 32'h0);
    chk("rstmid_ready", 32'(StReady), 32'h1);

    // load and unknown opcodes are consumed without any write or error
    drive(1'b1, 6'h23, 32'h0000_0004, 32'hFFFF_FFFF);
    cyc();
    chk("lw_we", 32'(MemWe), 32'h0);
    chk("lw_err", 32'(AlignErr), 32'h0);
    chk("lw_ready", 32'(StReady), 32'h1);
    drive(1'b1, 6'h00, 32'h0000_0003, 32'hFFFF_FFFF);
    cyc();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    chk("nop_we", 32'(MemWe), 32'h0);
    chk("nop_err", 32'(AlignErr), 32'h0);
    chk("nop_hold_lane0", 32'(Mem0In), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
